// File: rtl/mem_responder_multiciclo.sv
// Memory responder for the multicycle RISC-V datapath: unified word RAM with
// byte/half/word access, a programmable number of wait states and a one-cycle oReady pulse.
module mem_responder_multiciclo #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iLeMem,
  input  logic        iEscreveMem,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oRData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oErro,
  output logic [1:0]  oState
);

  // Handshake: a strobe seen high in IDLE is captured on that edge; oReady is
  // high for exactly one cycle (RESP). Strobes outside IDLE are ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam int AW = ADDR_WIDTH + 2;
  localparam logic [3:0] WS_M1 = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       rdata_q;
  logic              erro_q;
  logic              capture;
  logic              go_resp;

  logic [31:0]       mem [2**ADDR_WIDTH];

  logic [AW-1:0]     req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              req_we;
  logic              req_err;
  logic [3:0]        req_be;
  logic [31:0]       req_lanes;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_result;
  logic              commit_wr;
  logic              unused_addr;

  assign unused_addr = ^iAddr[31:AW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iEscreveMem || iLeMem) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign go_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // With zero wait states RESP is entered on the capture edge itself, so the
  // access must use the live inputs instead of the not-yet-latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_addr   = iAddr[AW-1:0];
      req_wdata  = iWData;
      req_funct3 = iFunct3;
      req_we     = iEscreveMem;
    end else begin
      req_addr   = addr_q;
      req_wdata  = wdata_q;
      req_funct3 = funct3_q;
      req_we     = we_q;
    end
  end

  always_comb begin
    req_err   = 1'b0;
    req_be    = 4'b0000;
    req_lanes = req_wdata;
    case (req_funct3)
      3'b000: begin
        req_be    = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        req_err   = req_addr[0];
        req_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        req_lanes = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        req_err = (req_addr[1:0] != 2'b00);
        req_be  = 4'b1111;
      end
      3'b100, 3'b101: req_err = req_we;
      default:        req_err = 1'b1;
    endcase
  end

  assign rd_word = mem[req_addr[AW-1:2]];

  always_comb begin
    rd_byte   = rd_word[8*req_addr[1:0] +: 8];
    rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    rd_result = 32'd0;
    case (req_funct3)
      3'b000:  rd_result = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_result = {{16{rd_half[15]}}, rd_half};
      3'b010:  rd_result = rd_word;
      3'b100:  rd_result = {24'd0, rd_byte};
      3'b101:  rd_result = {16'd0, rd_half};
      default: rd_result = 32'd0;
    endcase
  end

  assign commit_wr = go_resp && req_we && !req_err && !iRST;

  always_ff @(posedge iCLK) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[req_addr[AW-1:2]][8*i +: 8] <= req_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      rdata_q  <= 32'd0;
      erro_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q   <= iAddr[AW-1:0];
        wdata_q  <= iWData;
        funct3_q <= iFunct3;
        we_q     <= iEscreveMem;
      end
      if (go_resp) begin
        erro_q  <= req_err;
        rdata_q <= (req_err || req_we) ? 32'd0 : rd_result;
      end else if (state_q == S_RESP) begin
        erro_q  <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  assign oRData = rdata_q;
  assign oReady = (state_q == S_RESP);
  assign oBusy  = (state_q != S_IDLE);
  assign oErro  = erro_q;
  assign oState = state_q;

endmodule

// File: tb/tb_mem_responder_multiciclo.sv
// Directed bench for mem_responder_multiciclo: driver tasks push expected
// responses into a queue, a negedge monitor pops them whenever oReady is seen.
module tb_mem_responder_multiciclo;

  localparam int WS = 1;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iLeMem = 1'b0;
  logic        iEscreveMem = 1'b0;
  logic [31:0] iAddr = 32'd0;
  logic [31:0] iWData = 32'd0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] oRData;
  logic        oReady;
  logic        oBusy;
  logic        oErro;
  logic [1:0]  oState;

  int checks = 0;
  int failures = 0;
  // {check_data, erro, rdata}
  logic [33:0] exp_q[$];

  mem_responder_multiciclo #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
    .iCLK(iCLK), .iRST(iRST), .iLeMem(iLeMem), .iEscreveMem(iEscreveMem),
    .iAddr(iAddr), .iWData(iWData), .iFunct3(iFunct3), .oRData(oRData),
    .oReady(oReady), .oBusy(oBusy), .oErro(oErro), .oState(oState)
  );

  // clock / reset
  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (oReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check("resp_erro", {31'd0, oErro}, {31'd0, e[32]});
          if (e[33]) check("resp_rdata", oRData, e[31:0]);
          check("resp_busy", {31'd0, oBusy}, 32'd1);
          check("resp_state", {30'd0, oState}, 32'd2);
        end
      end else begin
        check("idle_erro", {31'd0, oErro}, 32'd0);
        check("idle_rdata", oRData, 32'd0);
      end
    end
  end

  task automatic wait_ready(output int lat);
    lat = 1;
    while (!oReady && lat < 20) begin
      @(negedge iCLK);
      lat++;
    end
    if (!oReady) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // driver: one transaction, strobes dropped after the capture edge
  task automatic req(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [2:0] f3,
                     input logic chk, input logic err, input logic [31:0] exp_d);
    int lat;
    @(negedge iCLK);
    iEscreveMem = we; iLeMem = re; iAddr = addr; iWData = wd; iFunct3 = f3;
    exp_q.push_back({chk, err, exp_d});
    @(posedge iCLK);
    @(negedge iCLK);
    iEscreveMem = 1'b0; iLeMem = 1'b0;
    wait_ready(lat);
    check("latency", lat, WS + 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3, input logic err);
    req(1'b1, 1'b0, addr, wd, f3, err, err, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] f3, input logic err, input logic [31:0] exp_d);
    req(1'b0, 1'b1, addr, 32'd0, f3, 1'b1, err, exp_d);
  endtask

  initial begin
    int lat;
    #2 iRST = 1'b1;
    #1;
    check("rst_state", {30'd0, oState}, 32'd0);
    check("rst_ready", {31'd0, oReady}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_erro", {31'd0, oErro}, 32'd0);
    check("rst_rdata", oRData, 32'd0);
    @(negedge iCLK); @(negedge iCLK);
    iRST = 1'b0;

    wr(32'h10, 32'hDEADBEEF, 3'b010, 1'b0);
    rd(32'h10, 3'b010, 1'b0, 32'hDEADBEEF);
    rd(32'h13, 3'b000, 1'b0, 32'hFFFFFFDE);
    rd(32'h13, 3'b100, 1'b0, 32'h000000DE);
    rd(32'h10, 3'b001, 1'b0, 32'hFFFFBEEF);
    rd(32'h12, 3'b101, 1'b0, 32'h0000DEAD);
    rd(32'h12, 3'b001, 1'b0, 32'hFFFFDEAD);

    wr(32'h11, 32'h000000AA, 3'b000, 1'b0);
    rd(32'h10, 3'b010, 1'b0, 32'hDEADAAEF);
    rd(32'h11, 3'b000, 1'b0, 32'hFFFFFFAA);

    rd(32'h11, 3'b010, 1'b1, 32'd0);
    wr(32'h13, 32'h0000FFFF, 3'b001, 1'b1);
    wr(32'h10, 32'h00000055, 3'b100, 1'b1);
    rd(32'h10, 3'b011, 1'b1, 32'd0);
    rd(32'h10, 3'b010, 1'b0, 32'hDEADAAEF);

    req(1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010, 1'b0, 1'b0, 32'd0);
    rd(32'h20, 3'b010, 1'b0, 32'h12345678);
    rd(32'h420, 3'b010, 1'b0, 32'h12345678);

    // reset during WAIT drops the pending store
    wr(32'h30, 32'h11112222, 3'b010, 1'b0);
    @(negedge iCLK);
    iEscreveMem = 1'b1; iAddr = 32'h30; iWData = 32'h99999999; iFunct3 = 3'b010;
    @(posedge iCLK);
    @(negedge iCLK);
    iEscreveMem = 1'b0;
    check("pre_rst_state", {30'd0, oState}, 32'd1);
    iRST = 1'b1;
    #1;
    check("mid_rst_state", {30'd0, oState}, 32'd0);
    check("mid_rst_busy", {31'd0, oBusy}, 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    check("post_rst_state", {30'd0, oState}, 32'd0);
    rd(32'h30, 3'b010, 1'b0, 32'h11112222);

    // strobe held through RESP starts a second transaction
    @(negedge iCLK);
    iLeMem = 1'b1; iAddr = 32'h20; iFunct3 = 3'b010;
    exp_q.push_back({2'b10, 32'h12345678});
    exp_q.push_back({2'b10, 32'h12345678});
    @(negedge iCLK);
    wait_ready(lat);
    @(negedge iCLK);
    check("held_idle_state", {30'd0, oState}, 32'd0);
    @(negedge iCLK);
    check("held_rewait_state", {30'd0, oState}, 32'd1);
    iLeMem = 1'b0;
    wait_ready(lat);
    repeat (3) @(negedge iCLK);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
